// File: rtl/vp_key_sched.sv
// vp_key_sched: merges PS/2 key events and gamepad numpad edges into one
// ordered event stream for vp_keymap. Each event is issued as a one-cycle
// strobe followed by a quiet gap so the console key scan can see it.
//
// Ports:
//   clk_i           system clock (clk_sys)
//   res_n_i         asynchronous active-low reset
//   flush_i         synchronous clear of queue, joystick tracking and FSM
//   ps2_valid_i     one-cycle strobe for a new PS/2 event
//   ps2_ascii_i     ASCII code of the PS/2 event (8'h00 = unmapped, ignored)
//   ps2_released_i  1 = key release, 0 = key press
//   joy_numpad_i    numpad button levels, bit0="1" .. bit8="9", bit9="0"
//   rx_data_ready_o one-cycle event strobe to vp_keymap
//   rx_ascii_o      event code, holds last issued value outside the strobe
//   rx_released_o   event release flag, holds last issued value
//   level_o         queue occupancy
//   overflow_o      sticky: a PS/2 event was dropped on a full queue
module vp_key_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4096,
  parameter int JOY_BITS   = 10
) (
  input  logic                        clk_i,
  input  logic                        res_n_i,
  input  logic                        flush_i,
  input  logic                        ps2_valid_i,
  input  logic [7:0]                  ps2_ascii_i,
  input  logic                        ps2_released_i,
  input  logic [JOY_BITS-1:0]         joy_numpad_i,
  output logic                        rx_data_ready_o,
  output logic [7:0]                  rx_ascii_o,
  output logic                        rx_released_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o
);

  // state | meaning
  // IDLE  | waiting for a queued event; pops and strobes it when one exists
  // GAP   | quiet period after a strobe, gap counter running down to 0

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam int IW = (JOY_BITS > 1) ? $clog2(JOY_BITS) : 1;

  typedef enum logic {IDLE, GAP} state_t;

  state_t              state;
  logic [CW-1:0]       gap_cnt;

  // PS/2 input stage; gives PS/2 and joystick events the same two-edge
  // path to the strobe.
  logic                ps2_vld_q;
  logic [7:0]          ps2_ascii_q;
  logic                ps2_rel_q;

  logic [JOY_BITS-1:0] prev;
  logic [JOY_BITS-1:0] pending;
  logic [JOY_BITS-1:0] chg;
  logic [JOY_BITS-1:0] svc_mask;
  logic                joy_hit;
  logic [IW-1:0]       joy_idx;
  logic [7:0]          joy_ascii;

  logic [8:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [8:0]          wr_data;
  logic                full;
  logic                pop;
  logic                can_push;
  logic                push_ps2;
  logic                push_joy;
  logic                push;
  logic                drop;

  assign chg  = joy_numpad_i ^ prev;
  assign full = (level_o == LW'(FIFO_DEPTH));
  assign pop  = (state == IDLE) && (level_o != '0);
  // A full queue still accepts a write in the cycle the FSM pops the head.
  assign can_push = !full || pop;
  assign push_ps2 = ps2_vld_q && can_push;
  assign drop     = ps2_vld_q && !can_push;
  assign push_joy = !ps2_vld_q && can_push && joy_hit;
  assign push     = push_ps2 || push_joy;

  // Lowest set pending bit wins.
  always_comb begin
    joy_hit = 1'b0;
    joy_idx = '0;
    for (int i = JOY_BITS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        joy_hit = 1'b1;
        joy_idx = IW'(i);
      end
    end
  end

  always_comb begin
    joy_ascii = 8'h30;
    if (8'(joy_idx) < 8'd9) joy_ascii = 8'h31 + 8'(joy_idx);
  end

  assign svc_mask = push_joy ? (JOY_BITS'(1) << joy_idx) : '0;
  // Joystick events carry the level at service time, not at edge time.
  assign wr_data  = push_ps2 ? {ps2_rel_q, ps2_ascii_q} : {~prev[joy_idx], joy_ascii};

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      ps2_vld_q   <= 1'b0;
      ps2_ascii_q <= '0;
      ps2_rel_q   <= 1'b0;
      prev        <= '0;
      pending     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
    end else if (flush_i) begin
      ps2_vld_q   <= 1'b0;
      ps2_ascii_q <= '0;
      ps2_rel_q   <= 1'b0;
      prev        <= '0;
      pending     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
    end else begin
      ps2_vld_q   <= ps2_valid_i && (ps2_ascii_i != 8'h00);
      ps2_ascii_q <= ps2_ascii_i;
      ps2_rel_q   <= ps2_released_i;
      prev        <= joy_numpad_i;
      // A bit that changes again in its service cycle stays pending.
      pending     <= (pending & ~svc_mask) | chg;
      if (drop) overflow_o <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      rx_data_ready_o <= 1'b0;
      rx_ascii_o      <= '0;
      rx_released_o   <= 1'b0;
    end else if (flush_i) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      rx_data_ready_o <= 1'b0;
      rx_ascii_o      <= '0;
      rx_released_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rx_data_ready_o <= 1'b0;
          if (pop) begin
            {rx_released_o, rx_ascii_o} <= mem[rd_ptr];
            rx_data_ready_o <= 1'b1;
            gap_cnt         <= CW'(GAP_CYCLES);
            state           <= GAP;
          end
        end
        GAP: begin
          rx_data_ready_o <= 1'b0;
          gap_cnt         <= gap_cnt - CW'(1);
          // Counter reaches 0 on the same edge that returns to IDLE, so
          // strobes are GAP_CYCLES+1 clocks apart under back-to-back load.
          if (gap_cnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vp_key_sched.sv
module tb_vp_key_sched;

  logic       clk = 1'b0;
  logic       res_n;
  logic       flush;
  logic       ps2_valid;
  logic [7:0] ps2_ascii;
  logic       ps2_released;
  logic [9:0] joy;

  logic       a_rdy, a_rel, a_ovf;
  logic [7:0] a_ascii;
  logic [3:0] a_level;
  logic       b_rdy, b_rel, b_ovf;
  logic [7:0] b_ascii;
  logic [3:0] b_level;

  always #5 clk = ~clk;

  vp_key_sched #(.FIFO_DEPTH(8), .GAP_CYCLES(4), .JOY_BITS(10)) u_fast (
    .clk_i(clk), .res_n_i(res_n), .flush_i(flush),
    .ps2_valid_i(ps2_valid), .ps2_ascii_i(ps2_ascii), .ps2_released_i(ps2_released),
    .joy_numpad_i(joy),
    .rx_data_ready_o(a_rdy), .rx_ascii_o(a_ascii), .rx_released_o(a_rel),
    .level_o(a_level), .overflow_o(a_ovf)
  );

  vp_key_sched #(.FIFO_DEPTH(8), .GAP_CYCLES(32), .JOY_BITS(10)) u_slow (
    .clk_i(clk), .res_n_i(res_n), .flush_i(flush),
    .ps2_valid_i(ps2_valid), .ps2_ascii_i(ps2_ascii), .ps2_released_i(ps2_released),
    .joy_numpad_i(joy),
    .rx_data_ready_o(b_rdy), .rx_ascii_o(b_ascii), .rx_released_o(b_rel),
    .level_o(b_level), .overflow_o(b_ovf)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         lvl_max_a = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int         ca[$];
  int         cb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder: {released, ascii} plus the cycle it was seen.
  always @(negedge clk) begin
    if (a_rdy === 1'b1) begin
      qa.push_back({a_rel, a_ascii});
      ca.push_back(cyc);
    end
    if (b_rdy === 1'b1) begin
      qb.push_back({b_rel, b_ascii});
      cb.push_back(cyc);
    end
    if (int'(a_level) > lvl_max_a) lvl_max_a = int'(a_level);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ev_a(input int i);
    if (i < qa.size()) return qa[i];
    return 9'hxxx;
  endfunction

  function automatic logic [8:0] ev_b(input int i);
    if (i < qb.size()) return qb[i];
    return 9'hxxx;
  endfunction

  function automatic int cy_a(input int i);
    if (i < ca.size()) return ca[i];
    return -1000;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    qa.delete(); qb.delete(); ca.delete(); cb.delete();
    lvl_max_a = 0;
  endtask

  task automatic do_flush();
    flush = 1'b1; ps2_valid = 1'b0; joy = '0;
    @(negedge clk);
    flush = 1'b0;
    clear_logs();
  endtask

  task automatic ps2(input logic [7:0] a, input logic r);
    ps2_valid = 1'b1; ps2_ascii = a; ps2_released = r;
    @(negedge clk);
    ps2_valid = 1'b0;
  endtask

  task automatic wait_qb(input int n, input int lim, input string tag);
    for (int i = 0; i < lim && qb.size() < n; i++) @(negedge clk);
    chk(tag, qb.size(), n);
  endtask

  initial begin
    res_n = 1'b0; flush = 1'b0; ps2_valid = 1'b0; ps2_ascii = '0;
    ps2_released = 1'b0; joy = '0;
    cycles(3);
    chk("rst_rdy", a_rdy, 0);
    chk("rst_ascii", a_ascii, 0);
    chk("rst_level", a_level, 0);
    chk("rst_ovf", b_ovf, 0);
    res_n = 1'b1;
    cycles(2);
    clear_logs();

    // PS/2 order and spacing
    ps2(8'h61, 1'b0);
    ps2(8'h61, 1'b1);
    cycles(12);
    chk("t1_count", qa.size(), 2);
    chk("t1_ev0", ev_a(0), 9'h061);
    chk("t1_ev1", ev_a(1), 9'h161);
    chk("t1_spacing", cy_a(1) - cy_a(0), 5);
    chk("t1_peak", (lvl_max_a >= 1 && lvl_max_a <= 2), 1);
    chk("t1_level", a_level, 0);

    // Joystick lowest-first, presses then releases
    do_flush();
    joy = 10'h005;
    cycles(12);
    chk("t2_count", qa.size(), 2);
    chk("t2_ev0", ev_a(0), 9'h031);
    chk("t2_ev1", ev_a(1), 9'h033);
    joy = 10'h000;
    cycles(12);
    chk("t2_count2", qa.size(), 4);
    chk("t2_ev2", ev_a(2), 9'h131);
    chk("t2_ev3", ev_a(3), 9'h133);
    chk("t2_level", a_level, 0);

    // PS/2 priority over a simultaneous joystick edge
    do_flush();
    joy = 10'h200;
    ps2(8'h7a, 1'b0);
    cycles(12);
    chk("t3_count", qa.size(), 2);
    chk("t3_ev0", ev_a(0), 9'h07a);
    chk("t3_ev1", ev_a(1), 9'h030);
    chk("t3_ovf", a_ovf, 0);

    // Overflow while the slow instance sits in GAP
    do_flush();
    ps2(8'h78, 1'b0);
    wait_qb(1, 10, "t4_first");
    for (int i = 0; i < 9; i++) ps2(8'(8'h41 + i), 1'b0);
    joy = 10'h001;
    cycles(3);
    chk("t4_ovf", b_ovf, 1);
    chk("t4_level", b_level, 8);
    wait_qb(10, 600, "t4_drain");
    for (int i = 0; i < 8; i++) chk("t4_order", ev_b(1 + i), {1'b0, 8'(8'h41 + i)});
    chk("t4_joy", ev_b(9), 9'h031);
    cycles(40);
    chk("t4_final_count", qb.size(), 10);

    // Asynchronous reset during GAP with 3 queued, joy bit2 held
    do_flush();
    for (int i = 0; i < 4; i++) ps2(8'(8'h70 + i), 1'b0);
    cycles(2);
    chk("t5_level_pre", b_level, 3);
    chk("t5_ascii_pre", b_ascii, 8'h70);
    joy = 10'h004;
    res_n = 1'b0;
    #1;
    chk("t5_rst_rdy", b_rdy, 0);
    chk("t5_rst_ascii", b_ascii, 0);
    chk("t5_rst_level", b_level, 0);
    chk("t5_rst_rel", b_rel, 0);
    cycles(2);
    clear_logs();
    res_n = 1'b1;
    cycles(40);
    chk("t5_count", qb.size(), 1);
    chk("t5_ev", ev_b(0), 9'h033);

    // Unmapped code filtering, then flush with queue and overflow set
    do_flush();
    ps2(8'h00, 1'b0);
    cycles(6);
    chk("t6_level0", b_level, 0);
    chk("t6_no_ev", qb.size() + qa.size(), 0);
    ps2(8'h78, 1'b0);
    wait_qb(1, 10, "t6_first");
    for (int i = 0; i < 10; i++) ps2(8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 400 && b_level != 4'd4; i++) @(negedge clk);
    chk("t6_level4", b_level, 4);
    chk("t6_ovf_set", b_ovf, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clear_logs();
    chk("t6_flush_level", b_level, 0);
    chk("t6_flush_ovf", b_ovf, 0);
    cycles(80);
    chk("t6_no_strobe", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vp_key_sched.md
Name: vp_key_sched

Overview:
- Merges PS/2 key events and gamepad numpad button changes into one ordered event stream for vp_keymap.
- Presents one event at a time to vp_keymap, with a guaranteed quiet gap between events so the console scan can observe each one.
- Generates an explicit release event for every gamepad button edge, so a button can no longer stay stuck pressed.
- Sits in the top level between the mist_io decode logic and vp_keymap, on clk_sys.

Parameters:
- FIFO_DEPTH, 8, event queue depth; power of two, at least 2.
- GAP_CYCLES, 4096, idle clocks enforced after each issued event before the next one; at least 1.
- JOY_BITS, 10, width of the numpad bitmap.

Ports:
- clk_i  in  1  system clock (clk_sys).
- res_n_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous clear of the queue and scheduler.
- ps2_valid_i  in  1  one-cycle strobe marking a new PS/2 event.
- ps2_ascii_i  in  8  ASCII code of the PS/2 event; 8'h00 means unmapped.
- ps2_released_i  in  1  1 = key release, 0 = key press.
- joy_numpad_i  in  JOY_BITS  level bitmap, 1 = pressed. bit0="1", bit1="2" … bit8="9", bit9="0".
- rx_data_ready_o  out  1  one-cycle event strobe to vp_keymap.
- rx_ascii_o  out  8  event code; valid while the strobe is high.
- rx_released_o  out  1  event release flag; valid while the strobe is high.
- level_o  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
- overflow_o  out  1  sticky flag: a PS/2 event was dropped.

Behaviour:
- Reset (res_n_i=0, asynchronous) clears everything:
  - all outputs 0;
  - queue empty;
  - joystick previous-level register 0;
  - pending mask 0;
  - FSM in IDLE.
  Buttons already held when reset releases therefore generate press events.
- flush_i=1 has the same effect as reset on the next edge, overflow_o included. flush_i takes precedence over every other input in that cycle.
- Joystick edge detection:
  - Each cycle, chg = joy_numpad_i ^ prev; prev <= joy_numpad_i.
  - pending <= (pending | chg) with the serviced bit cleared; the serviced bit is re-set if it changes again in that same cycle.
- Enqueue arbitration: at most one write per cycle.
  - Priority 1: ps2_valid_i with ps2_ascii_i != 0.
    - Queue full: event dropped, overflow_o <= 1.
    - Events with ps2_ascii_i == 0 are silently ignored.
  - Priority 2, only when no PS/2 write happens and the queue is not full: the lowest set pending bit i.
    - Enqueued as {ascii="1".."9" for i=0..8, "0" for i=9; released=~prev[i]}.
    - Bit i is then cleared in pending.
    - The event carries the level at service time. A press followed by a release before service yields one release event.
  - Joystick changes are never dropped; they wait in pending.
- Queue: synchronous FIFO of 9-bit entries {released, ascii}, in-order. A simultaneous push and pop is allowed when full.
- Output FSM:
  - IDLE: if queue not empty, pop the head, drive rx_ascii_o/rx_released_o, set rx_data_ready_o=1 for exactly one cycle, load the gap counter with GAP_CYCLES, go to GAP.
  - GAP: counter decrements each cycle; at 0, go to IDLE.
  - rx_ascii_o/rx_released_o hold the last issued value outside the strobe.
- Latency: an event sampled at edge k into an empty queue with the FSM in IDLE gives rx_data_ready_o high in the cycle following edge k+2.
- Issued-event spacing is exactly GAP_CYCLES+1 clocks between successive strobes when the queue stays non-empty.
- level_o counts entries, including during a simultaneous push/pop, which leaves it unchanged.

Test Plan:
- PS/2 order and spacing, GAP_CYCLES=4: ps2 'a' press, then 'a' release 1 cycle later.
  - Required: strobes exactly 5 clocks apart, carrying (0x61,0) then (0x61,1).
  - Required: level_o peaks at 1 or 2 and returns to 0.
- Joystick bits serviced lowest-first: joy_numpad 0x000 → 0x005.
  - Required: events ('1',0) then ('3',0).
  - Then 0x005 → 0x000: required ('1',1) then ('3',1). No stuck keys.
- PS/2 priority over joystick: ps2_valid and a joy bit9 edge in the same cycle.
  - Required: the PS/2 event is issued first, then ('0',0).
  - Required: no loss and overflow_o stays 0.
- Overflow with FIFO_DEPTH=8, FSM held in GAP with a large GAP_CYCLES.
  - Stimulus: 9 consecutive PS/2 events, then 1 joystick edge.
  - Required: overflow_o=1, level_o=8, the 9th PS/2 event absent.
  - Required: the joystick event is issued after the 8 queued events drain.
- Reset mid-operation: assert res_n_i low during GAP with 3 entries queued, while joy bit2 is held.
  - Required: outputs 0 immediately.
  - Required: after release, a single ('3',0) event and nothing else.
- Filtering and flush: ps2 code 0x00 → no event, level_o stays 0.
  - Then flush_i pulse with 4 entries queued and overflow_o=1: required level_o=0, overflow_o=0, no further strobes.
